decoder_3to8_pulse: RTL and testbench
=====================================

# decoder_3to8_pulse

Sequenced 3-to-8 one-hot decoder, the drive side paired with the 8-to-3 encoder. It accepts a 3-bit code through a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles. It then inserts an idle gap before accepting the next code. It sits between control logic that issues line indices and downstream logic expecting one-hot select or strobe lines, and it counts completed pulses.

## Interface
- HOLD, 4, cycles the one-hot output is held per accepted code; legal range 1 to 255
- GAP, 1, cycles output is all-zero after each pulse before the next accept; legal range 0 to 255
- CW, 16, width of pulse_count
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  reset, asynchronous and active-low
- enable  input  1  block enable; low aborts activity and blocks new accepts
- in_valid  input  1  in_code is valid
- in_code  input  3  line index to drive, 0 to 7
- in_ready  output  1  block can accept; combinational, = enable && (state == IDLE)
- y  output  8  registered one-hot output; bit in_code set while driving, else 0
- y_active  output  1  registered; 1 exactly while y is non-zero
- pulse_count  output  CW  registered count of completed (non-aborted) pulses; wraps

## Operation
- States: IDLE, DRIVE, GAP. One down-counter cnt, 8 bits, shared by DRIVE and GAP.
- IDLE: y=0, y_active=0. An accept occurs on an edge where in_valid && in_ready.
  - On accept: y <= 8'b1 << in_code, y_active <= 1, cnt <= HOLD-1, next state DRIVE.
  - No accept: stay in IDLE.
- DRIVE: y is held constant.
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: y <= 0, y_active <= 0, pulse_count <= pulse_count+1 (modulo 2^CW).
    - GAP > 0: cnt <= GAP-1, next state GAP.
    - GAP == 0: next state IDLE.
- GAP: y=0.
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: next state IDLE.
- in_code is sampled only on the accept edge. Changes to in_code or in_valid outside IDLE are ignored.
- Every 3-bit code is legal, so y is always exactly one-hot or zero.
- enable is sampled every edge. If enable is low, the edge takes priority over everything else in every state:
  - next state IDLE, y <= 0, y_active <= 0;
  - pulse_count is unchanged, so an aborted pulse is not counted, including one aborted on its final DRIVE cycle;
  - cnt value is don't-care.
- While enable is low, in_ready=0, so no accept occurs.
- If enable returns high, the block sits in IDLE and in_ready rises in the same cycle.
- Reset, asynchronous assert: state IDLE, y=0, y_active=0, pulse_count=0, cnt=0.
  - This takes effect immediately, including mid-pulse; y drops without waiting for a clock edge.
  - Deassertion is synchronised externally. The first active edge after deassertion can accept.

## Timing
- Accept at edge E0: y is one-hot from just after E0 until just after E_HOLD, which is exactly HOLD cycles.
- pulse_count increments at E_HOLD, visible the same cycle y returns to 0.
- y is zero for GAP cycles, from E_HOLD to E_(HOLD+GAP).
- in_ready rises after E_(HOLD+GAP). The earliest next accept is E_(HOLD+GAP+1).
- Minimum accept-to-accept spacing is HOLD+GAP+1 cycles. With defaults this is 6.
- Latency from accept edge to y valid is 0 cycles: y is registered on the accept edge itself.
- in_ready depends combinationally on enable. The upstream must not make in_valid depend combinationally on in_ready.

## Test plan
- Reset and idle: hold rst_n=0, then release with enable=1 and in_valid=0 for 10 cycles.
  - Required: y=0, y_active=0, pulse_count=0, in_ready=1 throughout.
- Single pulse, defaults: accept in_code=5 at E0.
  - Required: y=8'h20 for exactly 4 cycles, then 0.
  - Required: pulse_count=1 from E4, in_ready=0 from E0 to E5, next accept possible at E6.
- Back-to-back, all codes: hold in_valid=1 and step in_code through 0 to 7 on each accept.
  - Required: y sequence 01,02,04,08,10,20,40,80, each held 4 cycles.
  - Required: one zero cycle between pulses, accepts at E0, E6, E12, ..., pulse_count=8.
- Enable abort: accept in_code=3, then drop enable for one edge at E2.
  - Required: y=0 after E2, pulse_count unchanged, in_ready=0 while enable is low.
  - Required: a re-accept on the first edge with enable=1 succeeds.
- Async reset mid-pulse: assert rst_n low between edges while y=8'h80.
  - Required: y, y_active and pulse_count clear without a clock edge; state is IDLE after release.
- Parameter corners: HOLD=1, GAP=0, in_valid held high.
  - Required: accepts every 2 cycles, y one-hot for 1 cycle then 0 for 1 cycle.
  - With CW=2, required: pulse_count wraps 3 to 0 on the 4th pulse.

Source files
------------

// File: rtl/decoder_3to8_pulse_if.sv
// Handshake and output bundle for the sequenced 3-to-8 pulse decoder.
// The master issues line indices; the slave (decoder) drives one-hot lines and status.
interface decoder_3to8_pulse_if #(
  parameter int unsigned CW = 16
);
  logic          in_valid;
  logic [2:0]    in_code;
  logic          in_ready;
  logic [7:0]    y;
  logic          y_active;
  logic [CW-1:0] pulse_count;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready,
    input  y,
    input  y_active,
    input  pulse_count
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready,
    output y,
    output y_active,
    output pulse_count
  );
endinterface

// File: rtl/decoder_3to8_pulse.sv
// Sequenced 3-to-8 one-hot decoder: accepts a code, holds its line for HOLD
// cycles, idles for GAP cycles, and counts completed pulses.
module decoder_3to8_pulse #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1,
  parameter int unsigned CW   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  decoder_3to8_pulse_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP - 1);

  state_t        r_state;
  logic [7:0]    r_cnt;
  logic [7:0]    r_y;
  logic          r_y_active;
  logic [CW-1:0] r_pulse_count;

  logic          w_ready;
  logic          w_accept;

  assign w_ready  = enable && (r_state == S_IDLE);
  assign w_accept = w_ready && bus.in_valid;

  // DRIVE and GAP share one down-counter; enable low overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_y           <= '0;
      r_y_active    <= 1'b0;
      r_pulse_count <= '0;
    end else if (!enable) begin
      r_state    <= S_IDLE;
      r_y        <= '0;
      r_y_active <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_y        <= 8'(1) << bus.in_code;
            r_y_active <= 1'b1;
            r_cnt      <= HOLD_M1;
            r_state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_y           <= '0;
            r_y_active    <= 1'b0;
            r_pulse_count <= r_pulse_count + CW'(1);
            if (GAP > 0) begin
              r_cnt   <= GAP_M1;
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_y        <= '0;
          r_y_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.y           = r_y;
  assign bus.y_active    = r_y_active;
  assign bus.pulse_count = r_pulse_count;

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Randomized and directed bench for decoder_3to8_pulse, run on a default
// instance and a HOLD=1/GAP=0/CW=2 corner instance against a timeline model.
module tb_decoder_3to8_pulse;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  always #5 clk = ~clk;

  decoder_3to8_pulse_if #(.CW(16)) bus_a ();
  decoder_3to8_pulse_if #(.CW(2))  bus_b ();

  decoder_3to8_pulse #(.HOLD(4), .GAP(1), .CW(16)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus_a)
  );

  decoder_3to8_pulse #(.HOLD(1), .GAP(0), .CW(2)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus_b)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: a pulse is described by its age in edges since accept.
  int unsigned P_HOLD [2] = '{4, 1};
  int unsigned P_GAP  [2] = '{1, 0};
  int unsigned P_MOD  [2] = '{65536, 4};

  bit          m_busy [2];
  int unsigned m_age  [2];
  int unsigned m_code [2];
  int unsigned m_cnt  [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_age[d]  = 0;
      m_code[d] = 0;
      m_cnt[d]  = 0;
    end
  endfunction

  function automatic bit model_edge(int d, bit en, bit valid, int unsigned code);
    bit acc = 1'b0;
    if (!en) begin
      m_busy[d] = 1'b0;
    end else if (!m_busy[d]) begin
      if (valid) begin
        acc       = 1'b1;
        m_busy[d] = 1'b1;
        m_age[d]  = 0;
        m_code[d] = code;
      end
    end else begin
      m_age[d]++;
      if (m_age[d] == P_HOLD[d]) m_cnt[d] = (m_cnt[d] + 1) % P_MOD[d];
      if (m_age[d] >= P_HOLD[d] + P_GAP[d]) m_busy[d] = 1'b0;
    end
    return acc;
  endfunction

  function automatic int unsigned exp_y(int d);
    if (m_busy[d] && m_age[d] < P_HOLD[d]) return 32'd1 << m_code[d];
    return 0;
  endfunction

  task automatic check_outputs();
    check_val("a_y",      32'(bus_a.y),           exp_y(0));
    check_val("a_active", 32'(bus_a.y_active),    32'(exp_y(0) != 0));
    check_val("a_count",  32'(bus_a.pulse_count), m_cnt[0]);
    check_val("b_y",      32'(bus_b.y),           exp_y(1));
    check_val("b_active", 32'(bus_b.y_active),    32'(exp_y(1) != 0));
    check_val("b_count",  32'(bus_b.pulse_count), m_cnt[1]);
  endtask

  // One clock: drive inputs, check combinational ready, clock, check registers.
  task automatic tick(input bit en, input bit valid, input int unsigned code, output bit acc_a);
    bit acc_b;
    enable         = en;
    bus_a.in_valid = valid;
    bus_b.in_valid = valid;
    bus_a.in_code  = 3'(code);
    bus_b.in_code  = 3'(code);
    #1;
    check_val("a_ready", 32'(bus_a.in_ready), 32'(en && !m_busy[0]));
    check_val("b_ready", 32'(bus_b.in_ready), 32'(en && !m_busy[1]));
    @(posedge clk);
    acc_a = model_edge(0, en, valid, code);
    acc_b = model_edge(1, en, valid, code);
    #1;
    check_outputs();
  endtask

  initial begin
    bit          acc;
    int unsigned k;
    int unsigned guard;

    rst_n          = 1'b0;
    enable         = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_a.in_code  = '0;
    bus_b.in_code  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 0, acc);

    // Single pulse, code 5.
    tick(1'b1, 1'b1, 5, acc);
    check_val("single_accept", 32'(acc), 1);
    check_val("single_y", 32'(bus_a.y), 32'h20);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 0, acc);
    check_val("single_count", 32'(bus_a.pulse_count), 1);

    // Back-to-back with in_valid held, stepping through all codes.
    k = 0;
    guard = 0;
    while (k < 8 && guard < 100) begin
      tick(1'b1, 1'b1, k, acc);
      if (acc) k++;
      guard++;
    end
    check_val("b2b_accepts", k, 8);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 0, acc);
    check_val("b2b_count", 32'(bus_a.pulse_count), 9);

    // Enable abort two edges into a pulse, then immediate re-accept.
    tick(1'b1, 1'b1, 3, acc);
    tick(1'b1, 1'b0, 0, acc);
    tick(1'b0, 1'b1, 3, acc);
    check_val("abort_y", 32'(bus_a.y), 0);
    check_val("abort_count", 32'(bus_a.pulse_count), 9);
    tick(1'b1, 1'b1, 3, acc);
    check_val("reaccept", 32'(acc), 1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 0, acc);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 7), acc);
    end
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 0, acc);

    // Asynchronous reset while code 7 is being driven.
    tick(1'b1, 1'b1, 7, acc);
    tick(1'b1, 1'b0, 0, acc);
    check_val("pre_rst_y", 32'(bus_a.y), 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_y",      32'(bus_a.y),           0);
    check_val("rst_active", 32'(bus_a.y_active),    0);
    check_val("rst_count",  32'(bus_a.pulse_count), 0);
    check_val("rst_b_count", 32'(bus_b.pulse_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 2, acc);
    check_val("post_rst_accept", 32'(acc), 1);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, $urandom_range(0, 7), acc);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
